// File: rtl/ram_pkg.sv
// Shared RAM geometry defaults and requester IDs used by the arbiter and its block RAM.
package ram_pkg;

    localparam int DEF_RAM_WIDTH     = 16;
    localparam int DEF_RAM_ADDR_BITS = 14;

    // Requester IDs double as the arbiter's registered read-owner encoding.
    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] VID     = 2'd1;
    localparam logic [1:0] CPU     = 2'd2;

endpackage

// File: rtl/block_ram.sv
// Single-port write-first block RAM with one cycle of registered read latency.
module block_ram
    import ram_pkg::*;
#(
    parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
    parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [RAM_ADDR_BITS-1:0] addr,
    input  logic [RAM_WIDTH-1:0]     din,
    output logic [RAM_WIDTH-1:0]     dout
);

    logic [RAM_WIDTH-1:0] mem [0:(1<<RAM_ADDR_BITS)-1];
    logic [RAM_WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
                dout_q    <= din;
            end else begin
                dout_q    <= mem[addr];
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester RAM arbiter: video has priority, CPU is forced through after STARVE_LIMIT denials.
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int RAM_WIDTH     = DEF_RAM_WIDTH,
    parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vid_req,
    input  logic [RAM_ADDR_BITS-1:0] vid_addr,
    output logic                     vid_gnt,
    output logic                     vid_rvalid,
    output logic [RAM_WIDTH-1:0]     vid_rdata,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [RAM_ADDR_BITS-1:0] cpu_addr,
    input  logic [RAM_WIDTH-1:0]     cpu_wdata,
    output logic                     cpu_gnt,
    output logic                     cpu_rvalid,
    output logic [RAM_WIDTH-1:0]     cpu_rdata,
    output logic                     ram_en,
    output logic                     ram_wr_en,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]     ram_din,
    input  logic [RAM_WIDTH-1:0]     ram_dout
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic [1:0] owner_q, owner_d;
    logic       cpu_force;

    always_comb begin
        cpu_force = cpu_req && (starve_q == LIMIT);
        // Grants are gated by rst_n so reset silences the RAM without waiting for a clock.
        vid_gnt   = rst_n && vid_req && !cpu_force;
        cpu_gnt   = rst_n && cpu_req && (!vid_req || cpu_force);

        ram_en    = vid_gnt || cpu_gnt;
        ram_wr_en = cpu_gnt && cpu_we;
        ram_addr  = vid_gnt ? vid_addr : cpu_addr;
        ram_din   = cpu_wdata;

        starve_d = starve_q;
        if (!cpu_req || cpu_gnt) begin
            starve_d = 4'd0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
        end

        owner_d = ID_NONE;
        if (vid_gnt) begin
            owner_d = VID;
        end else if (cpu_gnt && !cpu_we) begin
            owner_d = CPU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 4'd0;
            owner_q  <= ID_NONE;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    assign vid_rvalid = (owner_q == VID);
    assign cpu_rvalid = (owner_q == CPU);
    assign vid_rdata  = ram_dout;
    assign cpu_rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and random traffic against ram_arbiter plus block_ram, checked by a memory model and scoreboard.
module tb_ram_arbiter;
    import ram_pkg::*;

    localparam int W   = 16;
    localparam int A   = 14;
    localparam int LIM = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         vid_req, vid_gnt, vid_rvalid;
    logic [A-1:0] vid_addr;
    logic [W-1:0] vid_rdata;
    logic         cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [A-1:0] cpu_addr;
    logic [W-1:0] cpu_wdata, cpu_rdata;
    logic         ram_en, ram_wr_en;
    logic [A-1:0] ram_addr;
    logic [W-1:0] ram_din, ram_dout;

    ram_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ram_en(ram_en), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    block_ram #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) u_ram (
        .clk(clk), .en(ram_en), .we(ram_wr_en), .addr(ram_addr),
        .din(ram_din), .dout(ram_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   who;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model_mem [int];
    int           vectors = 0;
    int           miscompares = 0;
    int           starve_m = 0;
    int           vid_wait = 0;
    int           cpu_wait = 0;
    int           dut_vid_gnts = 0;
    int           dut_cpu_gnts = 0;
    logic         eg_v = 1'b0;
    logic         eg_c = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check just after it, update the model at posedge.
    task automatic step(input logic vr, input logic [A-1:0] va, input logic cr,
                        input logic cw, input logic [A-1:0] ca, input logic [W-1:0] cd);
        exp_t e;
        logic force_m;
        vid_req = vr; vid_addr = va;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("vid_rvalid", 32'(vid_rvalid), 32'(e.who == VID));
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e.who == CPU));
            if (e.who == VID) chk("vid_rdata", 32'(vid_rdata), 32'(e.data));
            else              chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
        end else begin
            chk("vid_rvalid_idle", 32'(vid_rvalid), 32'd0);
            chk("cpu_rvalid_idle", 32'(cpu_rvalid), 32'd0);
        end
        force_m = cr && (starve_m == LIM);
        eg_v = vr && !force_m;
        eg_c = cr && (!vr || force_m);
        chk("vid_gnt",   32'(vid_gnt),   32'(eg_v));
        chk("cpu_gnt",   32'(cpu_gnt),   32'(eg_c));
        chk("one_hot",   32'(vid_gnt && cpu_gnt), 32'd0);
        chk("ram_en",    32'(ram_en),    32'(eg_v || eg_c));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(eg_c && cw));
        if (eg_v) chk("ram_addr_vid", 32'(ram_addr), 32'(va));
        else if (eg_c) begin
            chk("ram_addr_cpu", 32'(ram_addr), 32'(ca));
            if (cw) chk("ram_din", 32'(ram_din), 32'(cd));
        end
        if (vid_gnt) dut_vid_gnts++;
        if (cpu_gnt) dut_cpu_gnts++;
        if (cr) begin
            if (eg_c) begin
                chk("cpu_latency", 32'(cpu_wait <= LIM), 32'd1);
                cpu_wait = 0;
            end else cpu_wait++;
        end else cpu_wait = 0;
        if (vr) begin
            if (eg_v) begin
                chk("vid_latency", 32'(vid_wait <= LIM), 32'd1);
                vid_wait = 0;
            end else vid_wait++;
        end else vid_wait = 0;
        @(posedge clk);
        if (eg_v) sb.push_back('{VID, model_mem[int'(va)]});
        if (eg_c) begin
            if (cw) model_mem[int'(ca)] = cd;
            else    sb.push_back('{CPU, model_mem[int'(ca)]});
        end
        starve_m = (!cr || eg_c) ? 0 : ((starve_m == LIM) ? LIM : starve_m + 1);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_vid_gnt"},    32'(vid_gnt),    32'd0);
        chk({tag, "_cpu_gnt"},    32'(cpu_gnt),    32'd0);
        chk({tag, "_vid_rvalid"}, 32'(vid_rvalid), 32'd0);
        chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
        chk({tag, "_ram_en"},     32'(ram_en),     32'd0);
        chk({tag, "_ram_wr_en"},  32'(ram_wr_en),  32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         vr, cr, cw;
        logic [A-1:0] va, ca;
        logic [W-1:0] cd;

        // Reset held with both requests asserted: everything must stay quiet.
        rst_n = 1'b0;
        vid_req = 1'b1; vid_addr = '0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        #2;
        chk_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        vid_req = 1'b0; cpu_req = 1'b0;

        // Video read of a preloaded word.
        step(1'b0, '0, 1'b1, 1'b1, 14'h0010, 16'hBEEF);
        step(1'b1, 14'h0010, 1'b0, 1'b0, '0, '0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // CPU write then read of the same address in consecutive cycles.
        step(1'b0, '0, 1'b1, 1'b1, 14'h0123, 16'h5A5A);
        step(1'b0, '0, 1'b1, 1'b0, 14'h0123, 16'h0000);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // CPU denied once, then drops its request: no RAM access.
        step(1'b1, 14'h0010, 1'b1, 1'b1, 14'h0123, 16'h1111);
        step(1'b0, '0, 1'b0, 1'b1, 14'h0123, 16'h1111);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Reset pulsed in the cycle after a video read grant.
        step(1'b1, 14'h0010, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        cpu_req = 1'b1; vid_req = 1'b1;
        #1;
        chk_quiet("mid_reset");
        sb.delete();
        starve_m = 0; vid_wait = 0; cpu_wait = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);
        chk("after_reset_vid_rvalid", 32'(vid_rvalid), 32'd0);

        // Both requesting continuously: 4 video grants then 1 CPU grant, repeating.
        dut_vid_gnts = 0; dut_cpu_gnts = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 14'h0010, 1'b1, 1'b0, 14'h0123, '0);
        end
        chk("starve_vid_count", 32'(dut_vid_gnts), 32'd8);
        chk("starve_cpu_count", 32'(dut_cpu_gnts), 32'd2);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);

        // Preload the random-traffic window, then run random held requests.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, '0, 1'b1, 1'b1, A'(i), W'($urandom));
        end
        vr = 1'b0; cr = 1'b0; cw = 1'b0; va = '0; ca = '0; cd = '0;
        eg_v = 1'b0; eg_c = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!vr || eg_v) begin
                vr = 1'($urandom_range(0, 1));
                va = A'($urandom_range(0, 31));
            end
            if (!cr || eg_c) begin
                cr = 1'($urandom_range(0, 1));
                cw = 1'($urandom_range(0, 1));
                ca = A'($urandom_range(0, 31));
                cd = W'($urandom);
            end
            step(vr, va, cr, cw, ca, cd);
        end
        step(1'b0, '0, 1'b0, 1'b0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter RAM_WIDTH, 16, data word width in bits.
REQ-002 SHALL have parameter RAM_ADDR_BITS, 14, word address width.
REQ-003 SHALL have parameter STARVE_LIMIT, 4, consecutive denied CPU cycles before CPU is forced a grant (legal 1..15).
REQ-004 SHALL have a single clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-005 Ports, in this order:
  clk  in  1  rising-edge system clock
  rst_n  in  1  async active-low reset
  vid_req  in  1  video read request (level, held until vid_gnt)
  vid_addr  in  RAM_ADDR_BITS  video read address
  vid_gnt  out  1  video access issued this cycle
  vid_rvalid  out  1  vid_rdata valid this cycle
  vid_rdata  out  RAM_WIDTH  video read data
  cpu_req  in  1  CPU request (level, held until cpu_gnt)
  cpu_we  in  1  1 = write, 0 = read
  cpu_addr  in  RAM_ADDR_BITS  CPU address
  cpu_wdata  in  RAM_WIDTH  CPU write data
  cpu_gnt  out  1  CPU access issued this cycle
  cpu_rvalid  out  1  cpu_rdata valid this cycle (reads only)
  cpu_rdata  out  RAM_WIDTH  CPU read data
  ram_en  out  1  RAM port enable
  ram_wr_en  out  1  RAM write enable
  ram_addr  out  RAM_ADDR_BITS  RAM address
  ram_din  out  RAM_WIDTH  RAM write data
  ram_dout  in  RAM_WIDTH  RAM registered read data (1-cycle latency)

Function
REQ-006 Arbitration SHALL be combinational within a cycle; at most one of vid_gnt, cpu_gnt high per cycle.
REQ-007 Default priority: video over CPU; if only one requests, it SHALL be granted the same cycle.
REQ-008 starve counter SHALL increment each cycle cpu_req=1 and cpu_gnt=0, clear on cpu_gnt or cpu_req=0, saturate at STARVE_LIMIT.
REQ-009 When counter == STARVE_LIMIT and cpu_req=1, CPU SHALL win over a simultaneous vid_req that cycle.
REQ-010 On any grant: ram_en=1, ram_addr = granted address; ram_wr_en = cpu_we only on CPU grant, else 0; ram_din = cpu_wdata.
REQ-011 No grant: ram_en=0, ram_wr_en=0; ram_addr/ram_din don't-care (drive cpu values).
REQ-012 A read granted in cycle t SHALL produce the matching x_rvalid=1 in cycle t+1 only; writes produce no rvalid.
REQ-013 vid_rdata and cpu_rdata SHALL both equal ram_dout; consumers qualify with rvalid.
REQ-014 Back-to-back grants SHALL be allowed every cycle (full throughput, one access/cycle).
REQ-015 CPU write then read of same address in consecutive cycles SHALL return the written value (RAM write-first).
REQ-016 Requester dropping req without grant SHALL be legal and cause no RAM access.

Reset
REQ-017 rst_n=0 SHALL immediately force vid_gnt, cpu_gnt, vid_rvalid, cpu_rvalid, ram_en, ram_wr_en to 0 and clear starve counter and in-flight owner register.
REQ-018 A read in flight when reset asserts SHALL produce no rvalid after release.
REQ-019 Arbitration SHALL resume on the first rising clk edge after rst_n deasserts.

Structure
REQ-020 RAM_WIDTH, RAM_ADDR_BITS defaults and requester-ID constants (VID, CPU) SHALL live in shared package ram_pkg, also used by block_ram users.
REQ-021 No sub-module; ram_arbiter drives an externally instantiated block_ram, state = starve counter + 2-bit registered read-owner (none/vid/cpu).

Verification
REQ-022 vid_req only, addr 0x0010 holding 0xBEEF -> vid_gnt same cycle, vid_rvalid=1, vid_rdata=0xBEEF next cycle.
REQ-023 cpu_req we=1 addr 0x0123 wdata 0x5A5A, then we=0 same addr -> two cpu_gnt cycles, cpu_rvalid with 0x5A5A on third cycle.
REQ-024 vid_req and cpu_req held high continuously, STARVE_LIMIT=4 -> 4 vid_gnt, 1 cpu_gnt, repeating; never both grants high.
REQ-025 rst_n pulsed low in cycle after vid read grant -> vid_rvalid stays 0; all outputs 0 during reset.
REQ-026 Random req/we/addr traffic 10k cycles vs. reference memory model -> every rvalid data matches model, every request eventually granted within STARVE_LIMIT+1 cycles.
